// File: rtl/am_query_argmax.sv
// N-class associative-memory argmax: scans one class vector per cycle, scores it by
// bitwise agreement with the latched query and reports the best-scoring trained class.
module am_query_argmax #(
  parameter int DIM     = 1024,
  parameter int CLS_NUM = 10,
  parameter int CLS_DW  = 4,
  parameter int SIMI_W  = $clog2(DIM) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               q_valid,
  output logic               q_ready,
  input  logic [DIM-1:0]     q_hv,
  input  logic [CLS_NUM-1:0] cls_valid,
  output logic [CLS_DW-1:0]  am_addr,
  input  logic [DIM-1:0]     am_rdata,
  output logic               p_valid,
  input  logic               p_ready,
  output logic [CLS_DW-1:0]  predict,
  output logic [SIMI_W-1:0]  max_simi,
  output logic               no_match
);

  localparam int CHUNK   = 64;
  localparam int N_CHUNK = (DIM + CHUNK - 1) / CHUNK;
  localparam int PAD_W   = N_CHUNK * CHUNK;
  localparam int CW      = $clog2(CHUNK) + 1;
  localparam logic [CLS_DW-1:0] LAST_CLS = CLS_DW'(CLS_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [DIM-1:0]       q_hv_q, q_hv_d;
  logic [CLS_NUM-1:0]   cls_valid_q, cls_valid_d;
  logic [CLS_DW-1:0]    am_addr_q, am_addr_d;
  logic                 cmp_valid_q, cmp_valid_d;
  logic [CLS_DW-1:0]    cmp_idx_q, cmp_idx_d;
  logic                 best_found_q, best_found_d;
  logic [SIMI_W-1:0]    best_simi_q, best_simi_d;
  logic [CLS_DW-1:0]    best_idx_q, best_idx_d;
  logic                 q_ready_q, q_ready_d;
  logic                 p_valid_q, p_valid_d;
  logic [CLS_DW-1:0]    predict_q, predict_d;
  logic [SIMI_W-1:0]    max_simi_q, max_simi_d;
  logic                 no_match_q, no_match_d;

  logic [PAD_W-1:0]     agree_pad;
  logic [CW-1:0]        chunk_cnt [N_CHUNK];
  logic [SIMI_W-1:0]    simi;
  logic                 cls_ok;
  logic                 take;

  function automatic logic [CW-1:0] pop_chunk(input logic [CHUNK-1:0] v);
    logic [CW-1:0] acc;
    acc = '0;
    for (int b = 0; b < CHUNK; b++) begin
      acc = acc + CW'(v[b]);
    end
    return acc;
  endfunction

  // Agreement bits, zero-padded so the popcount splits into equal chunks.
  always_comb begin
    agree_pad = '0;
    agree_pad[DIM-1:0] = ~(q_hv_q ^ am_rdata);
  end

  generate
    for (genvar gi = 0; gi < N_CHUNK; gi++) begin : g_pop
      assign chunk_cnt[gi] = pop_chunk(agree_pad[gi*CHUNK +: CHUNK]);
    end
  endgenerate

  always_comb begin
    simi = '0;
    for (int i = 0; i < N_CHUNK; i++) begin
      simi = simi + SIMI_W'(chunk_cnt[i]);
    end
  end

  // am_rdata belongs to the address issued last cycle (cmp_idx_q).
  always_comb begin
    cls_ok = 1'b0;
    for (int c = 0; c < CLS_NUM; c++) begin
      if (cmp_idx_q == CLS_DW'(c)) begin
        cls_ok = cls_valid_q[c];
      end
    end
    take = cmp_valid_q && cls_ok && (!best_found_q || (simi > best_simi_q));
  end

  always_comb begin
    state_d      = state_q;
    q_hv_d       = q_hv_q;
    cls_valid_d  = cls_valid_q;
    am_addr_d    = am_addr_q;
    cmp_valid_d  = 1'b0;
    cmp_idx_d    = cmp_idx_q;
    best_found_d = best_found_q;
    best_simi_d  = best_simi_q;
    best_idx_d   = best_idx_q;
    q_ready_d    = q_ready_q;
    p_valid_d    = p_valid_q;
    predict_d    = predict_q;
    max_simi_d   = max_simi_q;
    no_match_d   = no_match_q;

    // Strict greater-than keeps the lowest index on ties.
    if (take) begin
      best_found_d = 1'b1;
      best_simi_d  = simi;
      best_idx_d   = cmp_idx_q;
    end

    case (state_q)
      S_IDLE: begin
        if (q_valid) begin
          q_hv_d       = q_hv;
          cls_valid_d  = cls_valid;
          best_found_d = 1'b0;
          best_simi_d  = '0;
          best_idx_d   = '0;
          am_addr_d    = '0;
          q_ready_d    = 1'b0;
          state_d      = S_SCAN;
        end
      end
      S_SCAN: begin
        cmp_valid_d = 1'b1;
        cmp_idx_d   = am_addr_q;
        if (am_addr_q == LAST_CLS) begin
          state_d = S_DRAIN;
        end else begin
          am_addr_d = am_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Result registers take the post-compare best so DONE shows the final answer.
        p_valid_d  = 1'b1;
        no_match_d = !best_found_d;
        predict_d  = best_found_d ? best_idx_d : '0;
        max_simi_d = best_found_d ? best_simi_d : '0;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (p_ready) begin
          p_valid_d = 1'b0;
          q_ready_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      q_hv_q       <= '0;
      cls_valid_q  <= '0;
      am_addr_q    <= '0;
      cmp_valid_q  <= 1'b0;
      cmp_idx_q    <= '0;
      best_found_q <= 1'b0;
      best_simi_q  <= '0;
      best_idx_q   <= '0;
      q_ready_q    <= 1'b1;
      p_valid_q    <= 1'b0;
      predict_q    <= '0;
      max_simi_q   <= '0;
      no_match_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_hv_q       <= q_hv_d;
      cls_valid_q  <= cls_valid_d;
      am_addr_q    <= am_addr_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_idx_q    <= cmp_idx_d;
      best_found_q <= best_found_d;
      best_simi_q  <= best_simi_d;
      best_idx_q   <= best_idx_d;
      q_ready_q    <= q_ready_d;
      p_valid_q    <= p_valid_d;
      predict_q    <= predict_d;
      max_simi_q   <= max_simi_d;
      no_match_q   <= no_match_d;
    end
  end

  assign q_ready  = q_ready_q;
  assign am_addr  = am_addr_q;
  assign p_valid  = p_valid_q;
  assign predict  = predict_q;
  assign max_simi = max_simi_q;
  assign no_match = no_match_q;

endmodule

// File: tb/tb_am_query_argmax.sv
// Bench for am_query_argmax: a transaction-level argmax model checked every cycle,
// plus directed queries with hand-derived expectations.
module tb_am_query_argmax;
  localparam int DIM     = 1024;
  localparam int CLS_NUM = 10;
  localparam int CLS_DW  = 4;
  localparam int SIMI_W  = 11;

  logic               clk = 1'b0;
  logic               rst;
  logic               q_valid;
  logic               q_ready;
  logic [DIM-1:0]     q_hv;
  logic [CLS_NUM-1:0] cls_valid;
  logic [CLS_DW-1:0]  am_addr;
  logic [DIM-1:0]     am_rdata;
  logic               p_valid;
  logic               p_ready;
  logic [CLS_DW-1:0]  predict;
  logic [SIMI_W-1:0]  max_simi;
  logic               no_match;

  am_query_argmax #(.DIM(DIM), .CLS_NUM(CLS_NUM), .CLS_DW(CLS_DW), .SIMI_W(SIMI_W)) dut (
    .clk(clk), .rst(rst), .q_valid(q_valid), .q_ready(q_ready), .q_hv(q_hv),
    .cls_valid(cls_valid), .am_addr(am_addr), .am_rdata(am_rdata), .p_valid(p_valid),
    .p_ready(p_ready), .predict(predict), .max_simi(max_simi), .no_match(no_match)
  );

  always #5 clk = ~clk;

  // Associative memory with one cycle of read latency.
  logic [DIM-1:0] am_mem [CLS_NUM];
  always @(posedge clk) am_rdata <= (int'(am_addr) < CLS_NUM) ? am_mem[am_addr] : '0;

  int n_cmp  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Argmax over trained classes; ascending scan with strict > gives lowest index on ties.
  function automatic void best_of(input logic [DIM-1:0] hv, input logic [CLS_NUM-1:0] cv,
                                  output logic [CLS_DW-1:0] pred, output logic [SIMI_W-1:0] s,
                                  output logic nm);
    int best = -1;
    int bi = 0;
    for (int c = 0; c < CLS_NUM; c++) begin
      if (cv[c]) begin
        int sc = DIM - $countones(hv ^ am_mem[c]);
        if (sc > best) begin
          best = sc;
          bi = c;
        end
      end
    end
    nm   = (best < 0);
    pred = (best < 0) ? '0 : CLS_DW'(bi);
    s    = (best < 0) ? '0 : SIMI_W'(best);
  endfunction

  // Transaction model: idle / busy for CLS_NUM+2 edges / result held until p_ready.
  int                m_phase = 0;
  int                m_cnt = 0;
  logic              m_qready = 1'b1, m_pvalid = 1'b0, m_nm = 1'b0, pend_nm;
  logic [CLS_DW-1:0] m_pred = '0, pend_pred;
  logic [SIMI_W-1:0] m_simi = '0, pend_simi;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_qready = 1'b1; m_pvalid = 1'b0;
      m_pred = '0; m_simi = '0; m_nm = 1'b0;
    end else begin
      case (m_phase)
        0: if (q_valid) begin
          best_of(q_hv, cls_valid, pend_pred, pend_simi, pend_nm);
          m_phase = 1; m_cnt = 1; m_qready = 1'b0;
        end
        1: begin
          m_cnt++;
          if (m_cnt == CLS_NUM + 2) begin
            m_phase = 2; m_pvalid = 1'b1;
            m_pred = pend_pred; m_simi = pend_simi; m_nm = pend_nm;
          end
        end
        default: if (p_ready) begin
          m_phase = 0; m_pvalid = 1'b0; m_qready = 1'b1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("q_ready", 32'(q_ready), 32'(m_qready));
      chk("p_valid", 32'(p_valid), 32'(m_pvalid));
      chk("predict", 32'(predict), 32'(m_pred));
      chk("max_simi", 32'(max_simi), 32'(m_simi));
      chk("no_match", 32'(no_match), 32'(m_nm));
      chk("am_addr_range", 32'(int'(am_addr) <= CLS_NUM - 1), 32'd1);
    end
  end

  // Issue one query from IDLE; returns at the negedge where p_valid is first seen.
  task automatic send(input logic [DIM-1:0] hv, input logic [CLS_NUM-1:0] cv, output int lat);
    @(posedge clk); #1;
    q_valid = 1'b1; q_hv = hv; cls_valid = cv;
    @(posedge clk); #1;
    q_valid = 1'b0; q_hv = ~hv; cls_valid = '1;
    lat = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (p_valid) break;
      @(posedge clk);
      lat++;
    end
  endtask

  int lat;
  int exp_s;
  int rises [4];
  int nr;
  logic prev_pv;

  initial begin
    rst = 1'b1; q_valid = 1'b0; p_ready = 1'b1; q_hv = '0; cls_valid = '0;
    for (int c = 0; c < CLS_NUM; c++)
      for (int w = 0; w < DIM / 32; w++) am_mem[c][w*32 +: 32] = $urandom;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    chk("reset_q_ready", 32'(q_ready), 32'd1);
    chk("reset_p_valid", 32'(p_valid), 32'd0);
    chk("reset_predict", 32'(predict), 32'd0);
    chk("reset_am_addr", 32'(am_addr), 32'd0);

    send(am_mem[7], '1, lat);
    $display("query q=AM[7] all-valid: predict=%0d max_simi=%0d lat=%0d", predict, max_simi, lat);
    chk("exact_lat", lat, 12);
    chk("exact_predict", 32'(predict), 32'd7);
    chk("exact_simi", 32'(max_simi), 32'd1024);
    chk("exact_nomatch", 32'(no_match), 32'd0);

    am_mem[5] = am_mem[2];
    send(am_mem[2], '1, lat);
    $display("query tie AM[2]=AM[5]: predict=%0d max_simi=%0d", predict, max_simi);
    chk("tie_predict", 32'(predict), 32'd2);
    chk("tie_simi", 32'(max_simi), 32'd1024);

    exp_s = DIM - $countones(am_mem[3] ^ am_mem[0]);
    send(am_mem[3], 10'b0000000001, lat);
    $display("query disabled winner: predict=%0d max_simi=%0d no_match=%0d", predict, max_simi, no_match);
    chk("dis_predict", 32'(predict), 32'd0);
    chk("dis_nomatch", 32'(no_match), 32'd0);
    chk("dis_simi", 32'(max_simi), 32'(exp_s));

    send(am_mem[3], '0, lat);
    $display("query none valid: predict=%0d max_simi=%0d no_match=%0d", predict, max_simi, no_match);
    chk("none_nomatch", 32'(no_match), 32'd1);
    chk("none_predict", 32'(predict), 32'd0);
    chk("none_simi", 32'(max_simi), 32'd0);

    @(posedge clk); #1 p_ready = 1'b0;
    send(am_mem[9], '1, lat);
    repeat (20) @(negedge clk);
    $display("query backpressure: predict=%0d p_valid=%0d q_ready=%0d", predict, p_valid, q_ready);
    chk("bp_lat", lat, 12);
    chk("bp_q_ready", 32'(q_ready), 32'd0);
    chk("bp_predict", 32'(predict), 32'd9);
    chk("bp_p_valid", 32'(p_valid), 32'd1);
    @(posedge clk); #1 p_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_p_valid", 32'(p_valid), 32'd0);
    chk("bp_release_q_ready", 32'(q_ready), 32'd1);

    @(posedge clk); #1;
    q_valid = 1'b1; q_hv = am_mem[6]; cls_valid = '1;
    @(posedge clk); #1 q_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    $display("reset mid-scan: q_ready=%0d p_valid=%0d", q_ready, p_valid);
    chk("rst_q_ready", 32'(q_ready), 32'd1);
    chk("rst_p_valid", 32'(p_valid), 32'd0);
    repeat (15) @(negedge clk);
    send(am_mem[6], '1, lat);
    $display("query after reset: predict=%0d max_simi=%0d lat=%0d", predict, max_simi, lat);
    chk("post_rst_lat", lat, 12);
    chk("post_rst_predict", 32'(predict), 32'd6);

    @(posedge clk); #1;
    q_valid = 1'b1; q_hv = am_mem[4]; cls_valid = '1;
    nr = 0; prev_pv = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (p_valid && !prev_pv && nr < 4) begin
        rises[nr] = k;
        nr++;
      end
      prev_pv = p_valid;
    end
    @(posedge clk); #1 q_valid = 1'b0;
    $display("back-to-back: %0d result pulses", nr);
    chk("b2b_pulses", 32'(nr >= 3), 32'd1);
    if (nr >= 3) begin
      chk("b2b_period1", rises[1] - rises[0], 13);
      chk("b2b_period2", rises[2] - rises[1], 13);
    end
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
